// File: rtl/mf_ce_gen_pkg.sv
// Shared definitions for the multi-channel fractional clock-enable generator.
package mf_ce_gen_pkg;

    // Config FSM states
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_APPLY = 1'b1;

    // Width of a channel index: max(1, clog2(n)).
    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // LSB position of channel ch inside a packed per-channel vector of w-bit fields.
    function automatic int def_lsb(input int ch, input int w);
        return ch * w;
    endfunction

endpackage

// File: rtl/mf_ce_gen_ch.sv
// One fractional accumulator channel: emits ce at a rate of inc/mod of refclk.
module mf_ce_gen_ch #(
    parameter int              ACC_W     = 24,
    parameter logic [ACC_W-1:0] DEF_INC   = '0,
    parameter logic [ACC_W-1:0] DEF_MOD   = '0,
    parameter logic [ACC_W-1:0] DEF_PHASE = '0
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             load,
    input  logic [ACC_W-1:0] inc,
    input  logic [ACC_W-1:0] mod,
    input  logic [ACC_W-1:0] phase,
    output logic             ce
);

    // Out-of-range phase, or a saturated channel, starts from zero.
    function automatic logic [ACC_W-1:0] preload(input logic [ACC_W-1:0] i,
                                                 input logic [ACC_W-1:0] m,
                                                 input logic [ACC_W-1:0] p);
        return (p < m && i < m) ? p : '0;
    endfunction

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;
    logic             disabled;
    logic             saturated;

    // Full-width sum so the wrap compare never overflows.
    always_comb begin
        sum       = {1'b0, acc} + {1'b0, inc};
        disabled  = (mod == '0) || (inc == '0);
        saturated = (inc >= mod);
    end

    // Accumulate; a wrap subtracts mod (fits in ACC_W since the result is below mod).
    always_ff @(posedge refclk) begin
        if (rst) begin
            acc <= preload(DEF_INC, DEF_MOD, DEF_PHASE);
            ce  <= 1'b0;
        end else if (load) begin
            acc <= preload(inc, mod, phase);
            ce  <= 1'b0;
        end else if (disabled) begin
            ce  <= 1'b0;
        end else if (saturated) begin
            acc <= '0;
            ce  <= 1'b1;
        end else if (sum >= {1'b0, mod}) begin
            acc <= acc + inc - mod;
            ce  <= 1'b1;
        end else begin
            acc <= sum[ACC_W-1:0];
            ce  <= 1'b0;
        end
    end

endmodule

// File: rtl/mf_ce_gen_multi.sv
// Multi-channel fractional clock-enable generator with runtime config and lock indication.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | ready for a config request (after the first post-reset cycle)
// S_APPLY | one cycle: write latched config to its channel, restart lock
module mf_ce_gen_multi
    import mf_ce_gen_pkg::*;
#(
    parameter int                      NUM_CH      = 3,
    parameter int                      ACC_W       = 24,
    parameter int                      LOCK_CYCLES = 1024,
    parameter logic [NUM_CH*ACC_W-1:0] DEF_INC     = {24'd1, 24'd1, 24'd1},
    parameter logic [NUM_CH*ACC_W-1:0] DEF_MOD     = {24'd12, 24'd12, 24'd3},
    parameter logic [NUM_CH*ACC_W-1:0] DEF_PHASE   = {24'd0, 24'd6, 24'd0}
) (
    input  logic                      refclk,
    input  logic                      rst,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [ch_w(NUM_CH)-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]          cfg_inc,
    input  logic [ACC_W-1:0]          cfg_mod,
    input  logic [ACC_W-1:0]          cfg_phase,
    output logic [NUM_CH-1:0]         ce,
    output logic                      locked
);

    localparam int CH_W  = ch_w(NUM_CH);
    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

    logic [0:0]       state;
    logic             started;
    logic [CH_W-1:0]  lat_ch;
    logic [ACC_W-1:0] lat_inc;
    logic [ACC_W-1:0] lat_mod;
    logic [ACC_W-1:0] lat_phase;
    logic [ACC_W-1:0] inc_r   [NUM_CH];
    logic [ACC_W-1:0] mod_r   [NUM_CH];
    logic [ACC_W-1:0] phase_r [NUM_CH];
    logic             apply_vld;
    logic [NUM_CH-1:0] ld;
    logic [CNT_W-1:0] cnt;

    assign cfg_ready = started && (state == S_IDLE);
    // Out-of-range channel still passes through S_APPLY but touches nothing.
    assign apply_vld = (state == S_APPLY) && (int'(lat_ch) < NUM_CH);

    // Per-channel load strobe during a valid apply cycle.
    always_comb begin
        ld = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ld[i] = apply_vld && (int'(lat_ch) == i);
        end
    end

    // Config handshake FSM; started keeps ready low for the first cycle after reset.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state     <= S_IDLE;
            started   <= 1'b0;
            lat_ch    <= '0;
            lat_inc   <= '0;
            lat_mod   <= '0;
            lat_phase <= '0;
        end else begin
            started <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (cfg_valid && cfg_ready) begin
                        lat_ch    <= cfg_ch;
                        lat_inc   <= cfg_inc;
                        lat_mod   <= cfg_mod;
                        lat_phase <= cfg_phase;
                        state     <= S_APPLY;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Per-channel config registers, reloaded from the packed defaults on reset.
    always_ff @(posedge refclk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst) begin
                inc_r[i]   <= DEF_INC[def_lsb(i, ACC_W) +: ACC_W];
                mod_r[i]   <= DEF_MOD[def_lsb(i, ACC_W) +: ACC_W];
                phase_r[i] <= DEF_PHASE[def_lsb(i, ACC_W) +: ACC_W];
            end else if (ld[i]) begin
                inc_r[i]   <= lat_inc;
                mod_r[i]   <= lat_mod;
                phase_r[i] <= lat_phase;
            end
        end
    end

    // Settle counter: saturates at LOCK_CYCLES-1, restarted by any valid apply.
    always_ff @(posedge refclk) begin
        if (rst || apply_vld) begin
            cnt    <= '0;
            locked <= 1'b0;
        end else if (!locked) begin
            if (cnt == CNT_W'(LOCK_CYCLES - 1)) begin
                locked <= 1'b1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [ACC_W-1:0] inc_sel;
        logic [ACC_W-1:0] mod_sel;
        logic [ACC_W-1:0] phase_sel;

        // On load the channel preloads from the incoming config, not the stale registers.
        assign inc_sel   = ld[g] ? lat_inc   : inc_r[g];
        assign mod_sel   = ld[g] ? lat_mod   : mod_r[g];
        assign phase_sel = ld[g] ? lat_phase : phase_r[g];

        mf_ce_gen_ch #(
            .ACC_W    (ACC_W),
            .DEF_INC  (DEF_INC[def_lsb(g, ACC_W) +: ACC_W]),
            .DEF_MOD  (DEF_MOD[def_lsb(g, ACC_W) +: ACC_W]),
            .DEF_PHASE(DEF_PHASE[def_lsb(g, ACC_W) +: ACC_W])
        ) u_ch (
            .refclk(refclk),
            .rst   (rst),
            .load  (ld[g]),
            .inc   (inc_sel),
            .mod   (mod_sel),
            .phase (phase_sel),
            .ce    (ce[g])
        );
    end

endmodule

// File: tb/tb_mf_ce_gen_multi.sv
// Self-checking bench for mf_ce_gen_multi (3 channels, LOCK_CYCLES=16).
module tb_mf_ce_gen_multi;

    localparam int LOCK = 16;

    logic        refclk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_ch = '0;
    logic [23:0] cfg_inc = '0;
    logic [23:0] cfg_mod = '0;
    logic [23:0] cfg_phase = '0;
    logic [2:0]  ce;
    logic        locked;

    int n_cmp = 0;
    int n_err = 0;

    mf_ce_gen_multi #(.LOCK_CYCLES(LOCK)) dut (
        .refclk   (refclk),
        .rst      (rst),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_inc  (cfg_inc),
        .cfg_mod  (cfg_mod),
        .cfg_phase(cfg_phase),
        .ce       (ce),
        .locked   (locked)
    );

    always #5 refclk = ~refclk;

    // Reference model: per channel, config and edges elapsed since last (re)load.
    longint def_i [3] = '{1, 1, 1};
    longint def_m [3] = '{3, 12, 12};
    longint def_p [3] = '{0, 6, 0};
    longint m_inc [3];
    longint m_mod [3];
    longint m_ph  [3];
    longint m_k   [3];
    int     m_age;
    bit     m_started;
    bit     m_pending;
    int     m_pch;
    longint m_pinc, m_pmod, m_pph;

    // Pulse at edge k iff floor((p+k*inc)/mod) advances.
    function automatic logic exp_ce(int c);
        longint i, m, p, k;
        i = m_inc[c];
        m = m_mod[c];
        k = m_k[c];
        if (k == 0 || m == 0 || i == 0) return 1'b0;
        if (i >= m) return 1'b1;
        p = (m_ph[c] < m) ? m_ph[c] : 0;
        return ((p + k * i) / m) != ((p + (k - 1) * i) / m);
    endfunction

    function automatic logic [2:0] exp_vec();
        return {exp_ce(2), exp_ce(1), exp_ce(0)};
    endfunction

    function automatic logic exp_ready();
        return m_started && !m_pending;
    endfunction

    function automatic logic exp_locked();
        return m_age >= LOCK;
    endfunction

    task automatic model_edge(bit r, bit v, int ch, longint ii, longint mm, longint pp);
        bit rdy;
        bit loaded [3];
        if (r) begin
            for (int c = 0; c < 3; c++) begin
                m_inc[c] = def_i[c];
                m_mod[c] = def_m[c];
                m_ph[c]  = def_p[c];
                m_k[c]   = 0;
            end
            m_started = 0;
            m_pending = 0;
            m_age     = 0;
            return;
        end
        rdy = m_started && !m_pending;
        for (int c = 0; c < 3; c++) loaded[c] = 0;
        if (m_pending) begin
            m_pending = 0;
            if (m_pch < 3) begin
                m_inc[m_pch] = m_pinc;
                m_mod[m_pch] = m_pmod;
                m_ph[m_pch]  = m_pph;
                m_k[m_pch]   = 0;
                loaded[m_pch] = 1;
                m_age = -1;
            end
        end
        for (int c = 0; c < 3; c++) if (!loaded[c]) m_k[c]++;
        m_age++;
        if (v && rdy) begin
            m_pending = 1;
            m_pch  = ch;
            m_pinc = ii;
            m_pmod = mm;
            m_pph  = pp;
        end
        m_started = 1;
    endtask

    // One clock: capture inputs seen at the edge, then advance the model.
    task automatic tick();
        bit r, v;
        int ch;
        longint ii, mm, pp;
        r  = rst;
        v  = cfg_valid;
        ch = int'(cfg_ch);
        ii = longint'(cfg_inc);
        mm = longint'(cfg_mod);
        pp = longint'(cfg_phase);
        @(posedge refclk);
        #1;
        model_edge(r, v, ch, ii, mm, pp);
    endtask

    // Hold a request until accepted, then step through the apply edge.
    task automatic apply_cfg(int ch, int ii, int mm, int pp);
        bit ok;
        ok = 0;
        cfg_valid = 1;
        cfg_ch    = ch[1:0];
        cfg_inc   = ii[23:0];
        cfg_mod   = mm[23:0];
        cfg_phase = pp[23:0];
        for (int t = 0; t < 8 && !ok; t++) begin
            ok = cfg_ready;
            tick();
        end
        cfg_valid = 0;
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL cfg_accept ch=%0d: never ready within 8 cycles", ch);
        end else begin
            tick();
        end
    endtask

    task automatic test_reset();
        int p0, p1, p2, f1, f2, le;
        rst = 1;
        cfg_valid = 0;
        tick();
        tick();
        n_cmp += 3;
        if (ce !== 3'b000) begin n_err++; $display("FAIL reset_ce got=%b exp=000", ce); end
        if (locked !== 1'b0) begin n_err++; $display("FAIL reset_locked got=%b exp=0", locked); end
        if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b exp=0", cfg_ready); end
        rst = 0;
        p0 = 0; p1 = 0; p2 = 0; f1 = -1; f2 = -1; le = -1;
        for (int e = 1; e <= 48; e++) begin
            tick();
            n_cmp += 3;
            if (ce !== exp_vec()) begin n_err++; $display("FAIL reset_run_ce e=%0d got=%b exp=%b", e, ce, exp_vec()); end
            if (locked !== exp_locked()) begin n_err++; $display("FAIL reset_run_locked e=%0d got=%b exp=%b", e, locked, exp_locked()); end
            if (cfg_ready !== exp_ready()) begin n_err++; $display("FAIL reset_run_ready e=%0d got=%b exp=%b", e, cfg_ready, exp_ready()); end
            p0 += int'(ce[0]); p1 += int'(ce[1]); p2 += int'(ce[2]);
            if (ce[1] === 1'b1 && f1 < 0) f1 = e;
            if (ce[2] === 1'b1 && f2 < 0) f2 = e;
            if (locked === 1'b1 && le < 0) le = e;
        end
        n_cmp += 6;
        if (p0 != 16) begin n_err++; $display("FAIL reset_ch0_count got=%0d exp=16", p0); end
        if (p1 != 4) begin n_err++; $display("FAIL reset_ch1_count got=%0d exp=4", p1); end
        if (p2 != 4) begin n_err++; $display("FAIL reset_ch2_count got=%0d exp=4", p2); end
        if (f1 != 6) begin n_err++; $display("FAIL reset_ch1_first got=%0d exp=6", f1); end
        if (f2 != 12) begin n_err++; $display("FAIL reset_ch2_first got=%0d exp=12", f2); end
        if (le != LOCK) begin n_err++; $display("FAIL reset_lock_edge got=%0d exp=%0d", le, LOCK); end
    endtask

    task automatic test_rate();
        int pulses, adj, le;
        logic prev;
        n_cmp++;
        if (locked !== 1'b1) begin n_err++; $display("FAIL rate_pre_locked got=%b exp=1", locked); end
        apply_cfg(0, 5, 16, 0);
        n_cmp += 2;
        if (locked !== 1'b0) begin n_err++; $display("FAIL rate_lock_drop got=%b exp=0", locked); end
        if (ce[0] !== 1'b0) begin n_err++; $display("FAIL rate_apply_ce got=%b exp=0", ce[0]); end
        pulses = 0; adj = 0; le = -1; prev = 1'b0;
        for (int c = 1; c <= 160; c++) begin
            tick();
            n_cmp += 2;
            if (ce !== exp_vec()) begin n_err++; $display("FAIL rate_ce c=%0d got=%b exp=%b", c, ce, exp_vec()); end
            if (locked !== exp_locked()) begin n_err++; $display("FAIL rate_locked c=%0d got=%b exp=%b", c, locked, exp_locked()); end
            if (ce[0] === 1'b1 && prev === 1'b1) adj++;
            prev = ce[0];
            pulses += int'(ce[0]);
            if (locked === 1'b1 && le < 0) le = c;
        end
        n_cmp += 3;
        if (pulses != 50) begin n_err++; $display("FAIL rate_count got=%0d exp=50", pulses); end
        if (adj != 0) begin n_err++; $display("FAIL rate_adjacent got=%0d exp=0", adj); end
        if (le != LOCK) begin n_err++; $display("FAIL rate_relock got=%0d exp=%0d", le, LOCK); end
    endtask

    task automatic test_back_to_back();
        int low, le;
        low = 0; le = -1;
        for (int c = 0; c <= 24; c++) begin
            cfg_valid = (c == 0 || c == 4);
            cfg_ch    = 2'd1;
            cfg_inc   = 24'($urandom_range(1, 5));
            cfg_mod   = 24'($urandom_range(6, 15));
            cfg_phase = 24'($urandom_range(0, 15));
            tick();
            n_cmp += 3;
            if (ce !== exp_vec()) begin n_err++; $display("FAIL b2b_ce c=%0d got=%b exp=%b", c, ce, exp_vec()); end
            if (locked !== exp_locked()) begin n_err++; $display("FAIL b2b_locked c=%0d got=%b exp=%b", c, locked, exp_locked()); end
            if (cfg_ready !== exp_ready()) begin n_err++; $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, cfg_ready, exp_ready()); end
            if (cfg_ready === 1'b0) low++;
            if (locked === 1'b1 && le < 0 && c > 1) le = c;
        end
        cfg_valid = 0;
        n_cmp += 2;
        if (low != 2) begin n_err++; $display("FAIL b2b_ready_low got=%0d exp=2", low); end
        if (le != 5 + LOCK) begin n_err++; $display("FAIL b2b_relock got=%0d exp=%0d", le, 5 + LOCK); end
    endtask

    task automatic test_degenerate();
        int first;
        apply_cfg(2, 3, 0, 0);
        for (int c = 1; c <= 20; c++) begin
            tick();
            n_cmp += 2;
            if (ce !== exp_vec()) begin n_err++; $display("FAIL deg_mod0_model c=%0d got=%b exp=%b", c, ce, exp_vec()); end
            if (ce[2] !== 1'b0) begin n_err++; $display("FAIL deg_mod0 c=%0d got=%b exp=0", c, ce[2]); end
        end
        apply_cfg(2, 7, 7, 0);
        for (int c = 1; c <= 20; c++) begin
            tick();
            n_cmp += 2;
            if (ce !== exp_vec()) begin n_err++; $display("FAIL deg_sat_model c=%0d got=%b exp=%b", c, ce, exp_vec()); end
            if (ce[2] !== 1'b1) begin n_err++; $display("FAIL deg_sat c=%0d got=%b exp=1", c, ce[2]); end
        end
        apply_cfg(2, 1, 12, 20);
        first = -1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            n_cmp++;
            if (ce !== exp_vec()) begin n_err++; $display("FAIL deg_phase_model c=%0d got=%b exp=%b", c, ce, exp_vec()); end
            if (ce[2] === 1'b1 && first < 0) first = c;
        end
        n_cmp++;
        if (first != 12) begin n_err++; $display("FAIL deg_phase_first got=%0d exp=12", first); end
    endtask

    task automatic test_bad_ch();
        for (int t = 0; t < 40 && locked !== 1'b1; t++) tick();
        n_cmp++;
        if (locked !== 1'b1) begin n_err++; $display("FAIL badch_pre_locked got=%b exp=1", locked); end
        apply_cfg(3, 9, 10, 1);
        for (int c = 1; c <= 30; c++) begin
            tick();
            n_cmp += 2;
            if (ce !== exp_vec()) begin n_err++; $display("FAIL badch_ce c=%0d got=%b exp=%b", c, ce, exp_vec()); end
            if (locked !== 1'b1) begin n_err++; $display("FAIL badch_locked c=%0d got=%b exp=1", c, locked); end
        end
    endtask

    task automatic test_reset_in_apply();
        bit ok;
        int p0, f1, le;
        ok = 0;
        cfg_valid = 1;
        cfg_ch    = 2'd0;
        cfg_inc   = 24'd9;
        cfg_mod   = 24'd10;
        cfg_phase = 24'd0;
        for (int t = 0; t < 8 && !ok; t++) begin
            ok = cfg_ready;
            tick();
        end
        cfg_valid = 0;
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL rstapply_accept: never ready"); end
        rst = 1;
        tick();
        rst = 0;
        n_cmp += 3;
        if (ce !== 3'b000) begin n_err++; $display("FAIL rstapply_ce got=%b exp=000", ce); end
        if (locked !== 1'b0) begin n_err++; $display("FAIL rstapply_locked got=%b exp=0", locked); end
        if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL rstapply_ready got=%b exp=0", cfg_ready); end
        p0 = 0; f1 = -1; le = -1;
        for (int e = 1; e <= 48; e++) begin
            tick();
            n_cmp += 2;
            if (ce !== exp_vec()) begin n_err++; $display("FAIL rstapply_run_ce e=%0d got=%b exp=%b", e, ce, exp_vec()); end
            if (locked !== exp_locked()) begin n_err++; $display("FAIL rstapply_run_locked e=%0d got=%b exp=%b", e, locked, exp_locked()); end
            p0 += int'(ce[0]);
            if (ce[1] === 1'b1 && f1 < 0) f1 = e;
            if (locked === 1'b1 && le < 0) le = e;
        end
        n_cmp += 3;
        if (p0 != 16) begin n_err++; $display("FAIL rstapply_ch0_count got=%0d exp=16", p0); end
        if (f1 != 6) begin n_err++; $display("FAIL rstapply_ch1_first got=%0d exp=6", f1); end
        if (le != LOCK) begin n_err++; $display("FAIL rstapply_lock_edge got=%0d exp=%0d", le, LOCK); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ch    = 2'($urandom_range(0, 3));
            cfg_inc   = 24'($urandom_range(0, 20));
            cfg_mod   = 24'($urandom_range(0, 20));
            cfg_phase = 24'($urandom_range(0, 25));
            tick();
            n_cmp += 3;
            if (ce !== exp_vec()) begin n_err++; $display("FAIL rand_ce c=%0d got=%b exp=%b", c, ce, exp_vec()); end
            if (locked !== exp_locked()) begin n_err++; $display("FAIL rand_locked c=%0d got=%b exp=%b", c, locked, exp_locked()); end
            if (cfg_ready !== exp_ready()) begin n_err++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, cfg_ready, exp_ready()); end
        end
        rst = 0;
        cfg_valid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rate();
        test_back_to_back();
        test_degenerate();
        test_bad_ch();
        test_reset_in_apply();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
